// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM-stage data-memory access controller. Converts a load/store in the
//   MEM stage into a req/ack transaction on a variable-latency data memory,
//   stalls the front of the pipeline while the access is outstanding and
//   presents registered load data to WReg. Misaligned and timed-out accesses
//   raise a sticky error flag and load ERR_DATA.
//
// Parameters
//   TIMEOUT   max BUSY cycles waiting for DMAck before abort (>= 1)
//   ERR_DATA  value loaded into DMRD on an aborted or misaligned read
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   MemReadM          load in MEM stage
//   MemWriteM         store in MEM stage (wins when both are high)
//   ALUOutM, WDM      byte address and store data from EX/MEM
//   DMReq, DMWE       registered memory request and write enable
//   DMAddr, DMWD      registered address / store data, valid while DMReq
//   DMAck, DMRData    memory completion and read data
//   DMRD              registered load data to WReg
//   StallM            freeze PC/IF/ID/EX/MEM registers this cycle
//   DMErr             sticky error flag, cleared only by rst
//
// state | meaning
// IDLE  | no access outstanding; launches a request when an access shows up
// BUSY  | request on the bus, waiting for DMAck or timeout
// DONE  | access finished; pipeline advances, WReg captures DMRD
module mem_access_stage #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WDM,
  output logic        DMReq,
  output logic        DMWE,
  output logic [31:0] DMAddr,
  output logic [31:0] DMWD,
  input  logic        DMAck,
  input  logic [31:0] DMRData,
  output logic [31:0] DMRD,
  output logic        StallM,
  output logic        DMErr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          req_d, we_d, err_d, stall;
  logic [31:0]   addr_d, wd_d, rd_d;
  logic          access, aligned, is_read;

  assign access  = MemReadM | MemWriteM;
  assign aligned = (ALUOutM[1:0] == 2'b00);
  assign is_read = MemReadM & ~MemWriteM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      DMReq  <= 1'b0;
      DMWE   <= 1'b0;
      DMAddr <= '0;
      DMWD   <= '0;
      DMRD   <= '0;
      DMErr  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      DMReq  <= req_d;
      DMWE   <= we_d;
      DMAddr <= addr_d;
      DMWD   <= wd_d;
      DMRD   <= rd_d;
      DMErr  <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = DMReq;
    we_d    = DMWE;
    addr_d  = DMAddr;
    wd_d    = DMWD;
    rd_d    = DMRD;
    err_d   = DMErr;
    stall   = 1'b0;

    case (state)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (aligned) begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = ALUOutM;
            wd_d    = WDM;
            cnt_d   = '0;
          end else begin
            // Misaligned: skip the bus entirely and finish through DONE.
            state_d = DONE;
            err_d   = 1'b1;
            if (is_read) rd_d = ERR_DATA;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (DMAck) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!DMWE) rd_d = DMRData;
        end else if (cnt == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!DMWE) rd_d = ERR_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        // The same instruction is still on the M inputs here; never relaunch.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Reset forces the stall low at once even if an access is still presented.
  assign StallM = stall & ~rst;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam logic [31:0] ERR = 32'hBADD_A7A0;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUOutM, WDM;
  logic        DMReq, DMWE;
  logic [31:0] DMAddr, DMWD;
  logic        DMAck;
  logic [31:0] DMRData;
  logic [31:0] DMRD;
  logic        StallM, DMErr;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(16), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WDM(WDM),
    .DMReq(DMReq), .DMWE(DMWE), .DMAddr(DMAddr), .DMWD(DMWD),
    .DMAck(DMAck), .DMRData(DMRData),
    .DMRD(DMRD), .StallM(StallM), .DMErr(DMErr)
  );

  always #5 clk = ~clk;

  // Advance one cycle; registered outputs are stable 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WDM = '0;
    DMAck = 1'b0; DMRData = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #13;
    checks++; if (DMReq !== 1'b0) begin errors++; $display("FAIL reset_dmreq: got %b expected 0", DMReq); end
    checks++; if (DMWE !== 1'b0) begin errors++; $display("FAIL reset_dmwe: got %b expected 0", DMWE); end
    checks++; if (DMAddr !== 32'h0) begin errors++; $display("FAIL reset_dmaddr: got %h expected 0", DMAddr); end
    checks++; if (DMWD !== 32'h0) begin errors++; $display("FAIL reset_dmwd: got %h expected 0", DMWD); end
    checks++; if (DMRD !== 32'h0) begin errors++; $display("FAIL reset_dmrd: got %h expected 0", DMRD); end
    checks++; if (DMErr !== 1'b0) begin errors++; $display("FAIL reset_dmerr: got %b expected 0", DMErr); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", StallM); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    MemReadM = 1'b1; ALUOutM = 32'h100;
    #1;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL load_idle_stall: got %b expected 1", StallM); end
    checks++; if (DMReq !== 1'b0) begin errors++; $display("FAIL load_idle_req: got %b expected 0", DMReq); end
    step();
    checks++; if ({DMReq, DMWE, StallM} !== 3'b101) begin errors++; $display("FAIL load_busy1_ctl: got %b expected 101", {DMReq, DMWE, StallM}); end
    checks++; if (DMAddr !== 32'h100) begin errors++; $display("FAIL load_busy1_addr: got %h expected 00000100", DMAddr); end
    step();
    checks++; if ({DMReq, StallM} !== 2'b11) begin errors++; $display("FAIL load_busy2_ctl: got %b expected 11", {DMReq, StallM}); end
    DMAck = 1'b1; DMRData = 32'hCAFE_F00D;
    step();
    DMAck = 1'b0; DMRData = '0;
    checks++; if ({DMReq, StallM} !== 2'b00) begin errors++; $display("FAIL load_done_ctl: got %b expected 00", {DMReq, StallM}); end
    checks++; if (DMRD !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_done_rd: got %h expected cafef00d", DMRD); end
    checks++; if (DMErr !== 1'b0) begin errors++; $display("FAIL load_done_err: got %b expected 0", DMErr); end
    step();
    clear_inputs();
    #1;
    checks++; if ({DMReq, StallM} !== 2'b00) begin errors++; $display("FAIL load_after_idle: got %b expected 00", {DMReq, StallM}); end
  endtask

  task automatic test_store();
    MemWriteM = 1'b1; ALUOutM = 32'h204; WDM = 32'h1234_5678;
    #1;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL store_idle_stall: got %b expected 1", StallM); end
    step();
    // Upstream should be frozen, but disturb it to prove the bus holds.
    ALUOutM = 32'hFFFF_FFF0; WDM = 32'h0BAD_0BAD;
    DMAck = 1'b1; DMRData = 32'hDEAD_BEEF;
    #1;
    checks++; if ({DMReq, DMWE, StallM} !== 3'b111) begin errors++; $display("FAIL store_busy_ctl: got %b expected 111", {DMReq, DMWE, StallM}); end
    checks++; if (DMAddr !== 32'h204) begin errors++; $display("FAIL store_busy_addr: got %h expected 00000204", DMAddr); end
    checks++; if (DMWD !== 32'h1234_5678) begin errors++; $display("FAIL store_busy_wd: got %h expected 12345678", DMWD); end
    step();
    DMAck = 1'b0;
    checks++; if ({DMReq, StallM} !== 2'b00) begin errors++; $display("FAIL store_done_ctl: got %b expected 00", {DMReq, StallM}); end
    checks++; if (DMRD !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_rd_held: got %h expected cafef00d", DMRD); end
    step();
    clear_inputs();
  endtask

  task automatic test_both_high();
    MemReadM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h208; WDM = 32'h5555_AAAA;
    step();
    checks++; if ({DMReq, DMWE} !== 2'b11) begin errors++; $display("FAIL both_is_write: got %b expected 11", {DMReq, DMWE}); end
    DMAck = 1'b1; DMRData = 32'h7777_7777;
    step();
    DMAck = 1'b0;
    checks++; if (DMRD !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_rd_held: got %h expected cafef00d", DMRD); end
    step();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    MemReadM = 1'b1; ALUOutM = 32'h10;
    step();
    DMAck = 1'b1; DMRData = 32'h1111_1111;
    step();
    DMAck = 1'b0;
    checks++; if (DMRD !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first_rd: got %h expected 11111111", DMRD); end
    step();
    ALUOutM = 32'h14;
    #1;
    checks++; if ({DMReq, StallM} !== 2'b01) begin errors++; $display("FAIL b2b_no_dup: got %b expected 01", {DMReq, StallM}); end
    step();
    checks++; if (DMReq !== 1'b1) begin errors++; $display("FAIL b2b_second_req: got %b expected 1", DMReq); end
    checks++; if (DMAddr !== 32'h14) begin errors++; $display("FAIL b2b_second_addr: got %h expected 00000014", DMAddr); end
    DMAck = 1'b1; DMRData = 32'h2222_2222;
    step();
    DMAck = 1'b0;
    checks++; if (DMRD !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second_rd: got %h expected 22222222", DMRD); end
    step();
    clear_inputs();
  endtask

  task automatic test_misaligned();
    MemReadM = 1'b1; ALUOutM = 32'h102;
    #1;
    checks++; if ({DMReq, StallM} !== 2'b01) begin errors++; $display("FAIL mis_idle: got %b expected 01", {DMReq, StallM}); end
    step();
    checks++; if ({DMReq, StallM} !== 2'b00) begin errors++; $display("FAIL mis_done_ctl: got %b expected 00", {DMReq, StallM}); end
    checks++; if (DMRD !== ERR) begin errors++; $display("FAIL mis_rd: got %h expected %h", DMRD, ERR); end
    checks++; if (DMErr !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", DMErr); end
    step();
    clear_inputs();
    step();
    checks++; if ({DMErr, DMReq} !== 2'b10) begin errors++; $display("FAIL mis_err_sticky: got %b expected 10", {DMErr, DMReq}); end
  endtask

  task automatic test_rst_mid_busy();
    MemReadM = 1'b1; ALUOutM = 32'h400;
    step();
    checks++; if (DMReq !== 1'b1) begin errors++; $display("FAIL rst_busy_req: got %b expected 1", DMReq); end
    rst = 1'b1;
    #1;
    checks++; if ({DMReq, StallM, DMErr} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctl: got %b expected 000", {DMReq, StallM, DMErr}); end
    checks++; if (DMRD !== 32'h0) begin errors++; $display("FAIL rst_mid_rd: got %h expected 0", DMRD); end
    DMAck = 1'b1; DMRData = 32'h3333_3333;
    @(negedge clk);
    rst = 1'b0;
    MemReadM = 1'b0; ALUOutM = '0;
    step();
    checks++; if ({DMReq, StallM} !== 2'b00) begin errors++; $display("FAIL rst_after_ctl: got %b expected 00", {DMReq, StallM}); end
    checks++; if (DMRD !== 32'h0) begin errors++; $display("FAIL rst_late_ack_rd: got %h expected 0", DMRD); end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    int req_cycles;
    MemReadM = 1'b1; ALUOutM = 32'h300;
    step();
    req_cycles = 0;
    for (int i = 0; i < 40 && DMReq === 1'b1; i++) begin
      req_cycles++;
      step();
    end
    checks++; if (req_cycles !== 16) begin errors++; $display("FAIL to_req_cycles: got %0d expected 16", req_cycles); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL to_done_stall: got %b expected 0", StallM); end
    checks++; if (DMRD !== ERR) begin errors++; $display("FAIL to_rd: got %h expected %h", DMRD, ERR); end
    checks++; if (DMErr !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", DMErr); end
    step();
    clear_inputs();
    DMAck = 1'b1; DMRData = 32'h4444_4444;
    step();
    step();
    checks++; if ({DMReq, StallM} !== 2'b00) begin errors++; $display("FAIL to_late_ack_ctl: got %b expected 00", {DMReq, StallM}); end
    checks++; if (DMRD !== ERR) begin errors++; $display("FAIL to_late_ack_rd: got %h expected %h", DMRD, ERR); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_both_high();
    test_back_to_back();
    test_misaligned();
    test_rst_mid_busy();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
